quad_step_decoder: RTL

- Receiving end of the up/down step interface: decodes a 2-bit Gray-coded quadrature pair (a, b) back into up/down step pulses and a wrapping position count.
- Complements the up/down counter blocks. A step source emits a/b phases; this block reconstructs direction and position in the local clk domain.
- Includes input synchronisation, a power-up priming state machine, illegal-transition detection and optional glitch filtering.

---
 rtl/quad_step_decoder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/quad_step_decoder.sv
// Quadrature (a,b) decoder: synchronises the Gray-coded pair, emits up/down
// step pulses, keeps a wrapping count and flags illegal jumps. Macro: QSD_FILTER_EN.
module quad_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] cnt,
    output logic             up_pulse,
    output logic             dn_pulse,
    output logic             err,
    output logic             err_sticky
);
`ifdef QSD_FILTER_EN
    localparam int INIT_LEN = SYNC_STAGES + FILTER_LEN + 1;
`else
    localparam int INIT_LEN = SYNC_STAGES + 1;
`endif
    // counter sized for the longest priming period of either build
    localparam int ICW = $clog2(SYNC_STAGES + FILTER_LEN + 2);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t         state, state_nx;
    logic [ICW-1:0] init_cnt;
    logic [1:0]     sync_q [SYNC_STAGES];
    logic [1:0]     s, d, prev;
    logic [1:0]     pos_d, pos_p, delta;
    logic           fwd, rev, bad, init_done;

    // synchroniser chain for the asynchronous phase inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b00;
        end else begin
            sync_q[0] <= {a, b};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef QSD_FILTER_EN
    logic [1:0] hist [FILTER_LEN];
    logic [1:0] held;
    logic [1:0] ones, zeros;

    // history of synchronised samples and the last accepted value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < FILTER_LEN; j++) hist[j] <= 2'b00;
            held <= 2'b00;
        end else begin
            hist[0] <= s;
            for (int j = 1; j < FILTER_LEN; j++) hist[j] <= hist[j-1];
            held <= d;
        end
    end

    // a bit is accepted only when all recent samples agree
    always_comb begin
        ones  = 2'b11;
        zeros = 2'b11;
        for (int j = 0; j < FILTER_LEN; j++) begin
            ones  &= hist[j];
            zeros &= ~hist[j];
        end
        d = (held & ~(ones | zeros)) | ones;
    end
`else
    assign d = s;
`endif

    // Gray level to quarter-cycle position: 00,01,11,10 -> 0,1,2,3
    function automatic logic [1:0] gray_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    assign pos_d     = gray_pos(d);
    assign pos_p     = gray_pos(prev);
    assign delta     = pos_d - pos_p;
    assign fwd       = (delta == 2'd1);
    assign rev       = (delta == 2'd3);
    assign bad       = (delta == 2'd2);
    assign init_done = (init_cnt == ICW'(INIT_LEN - 1));

    // state register and priming counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_INIT) init_cnt <= init_cnt + ICW'(1);
        end
    end

    // leave INIT once the pipeline holds only post-reset samples
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT: if (init_done) state_nx = ST_RUN;
            ST_RUN:  state_nx = ST_RUN;
        endcase
    end

    // decode (prev, d) into pulses, count and error flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev       <= 2'b00;
            cnt        <= '0;
            up_pulse   <= 1'b0;
            dn_pulse   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            prev     <= d;
            up_pulse <= 1'b0;
            dn_pulse <= 1'b0;
            err      <= 1'b0;
            if (state == ST_RUN) begin
                err <= bad;
                if (bad) err_sticky <= 1'b1;
                if (enable && !clear) begin
                    unique case (1'b1)
                        fwd: begin
                            up_pulse <= 1'b1;
                            cnt      <= cnt + WIDTH'(1);
                        end
                        rev: begin
                            dn_pulse <= 1'b1;
                            cnt      <= cnt - WIDTH'(1);
                        end
                        default: ;
                    endcase
                end
            end
            if (clear) begin
                cnt        <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
